// File: rtl/path_test_sequencer.sv
// path_test_sequencer
//   Drives a 0-then-1 stimulus onto each single-input path under test, one
//   path at a time. After a programmable settle time it samples the path
//   output, compares it with the expected polarity and latches per-path
//   mismatch flags.
//
// Optional feature macro: PATH_MASK_EN
//   When defined, adds input path_en. Paths whose path_en bit is 0 are
//   skipped and take no cycles. If no path is enabled, the run ends at once.
//
// Ports
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   start     in   begin a run (accepted only in IDLE)
//   path_en   in   NUM_PATHS  per-path enable, captured at start (PATH_MASK_EN only)
//   resp_i    in   NUM_PATHS  path outputs
//   stim_o    out  NUM_PATHS  registered path inputs
//   busy      out  run in progress
//   done      out  one-cycle end-of-run pulse
//   cur_path  out  index of the path under test
//   fail0     out  NUM_PATHS  mismatch seen with stimulus 0
//   fail1     out  NUM_PATHS  mismatch seen with stimulus 1
module path_test_sequencer #(
  parameter int                   NUM_PATHS     = 4,
  parameter int                   SETTLE_CYCLES = 2,
  parameter logic [NUM_PATHS-1:0] INV_MASK      = '0,
  localparam int                  PW            = (NUM_PATHS > 1) ? $clog2(NUM_PATHS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef PATH_MASK_EN
  input  logic [NUM_PATHS-1:0] path_en,
`endif
  input  logic [NUM_PATHS-1:0] resp_i,
  output logic [NUM_PATHS-1:0] stim_o,
  output logic                 busy,
  output logic                 done,
  output logic [PW-1:0]        cur_path,
  output logic [NUM_PATHS-1:0] fail0,
  output logic [NUM_PATHS-1:0] fail1
);

  localparam int CW = 8;

  typedef enum logic [1:0] {IDLE, PH0, PH1, FIN} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [NUM_PATHS-1:0] start_mask, run_mask;

`ifdef PATH_MASK_EN
  logic [NUM_PATHS-1:0] en_q;
  assign start_mask = path_en;
  assign run_mask   = en_q;
`else
  assign start_mask = '1;
  assign run_mask   = '1;
`endif

  // Lowest set bit of m at or above index lo; MSB of the result is "found".
  function automatic logic [PW:0] first_from(input logic [NUM_PATHS-1:0] m, input int lo);
    logic [PW:0] r;
    r = '0;
    for (int i = NUM_PATHS - 1; i >= 0; i--)
      if (i >= lo && m[i]) r = {1'b1, PW'(i)};
    return r;
  endfunction

  logic [PW:0] first_sel, next_sel;
  logic        sample, mismatch, settled;

  assign first_sel = first_from(start_mask, 0);
  assign next_sel  = first_from(run_mask, int'(cur_path) + 1);
  assign settled   = (cnt == CW'(SETTLE_CYCLES));
  assign sample    = resp_i[cur_path];
  // Expected response is the current stimulus bit xor the path's inversion.
  assign mismatch  = sample ^ ((state == PH1) ^ INV_MASK[cur_path]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      stim_o   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cur_path <= '0;
      fail0    <= '0;
      fail1    <= '0;
`ifdef PATH_MASK_EN
      en_q     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            fail0  <= '0;
            fail1  <= '0;
            cnt    <= '0;
            stim_o <= '0;
`ifdef PATH_MASK_EN
            en_q   <= path_en;
`endif
            if (first_sel[PW]) begin
              cur_path <= first_sel[PW-1:0];
              busy     <= 1'b1;
              state    <= PH0;
            end else begin
              // Nothing to test: go straight to the end-of-run cycle.
              cur_path <= '0;
              done     <= 1'b1;
              state    <= FIN;
            end
          end
        end
        PH0: begin
          cnt <= cnt + 1'b1;
          if (settled) begin
            if (mismatch) fail0[cur_path] <= 1'b1;
            cnt    <= '0;
            stim_o <= NUM_PATHS'(1) << cur_path;
            state  <= PH1;
          end
        end
        PH1: begin
          cnt <= cnt + 1'b1;
          if (settled) begin
            if (mismatch) fail1[cur_path] <= 1'b1;
            cnt    <= '0;
            stim_o <= '0;
            if (next_sel[PW]) begin
              cur_path <= next_sel[PW-1:0];
              state    <= PH0;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_path_test_sequencer.sv
// Bench for path_test_sequencer: two instances (settle 2 and settle 4) drive
// behavioural path models (normal, stuck-at-0/1, delayed). A high-level model
// predicts every cycle of a run from the list of tested paths and predicts the
// final fail vectors from each path's fault type.
module tb_path_test_sequencer;

  localparam int          NP  = 4;
  localparam logic [3:0]  INV = 4'b0001;
  localparam int          SET [2] = '{2, 4};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start   [2];
  logic [3:0] path_en [2];
  logic [3:0] resp    [2];
  logic [3:0] stim    [2];
  logic       busy    [2];
  logic       done    [2];
  logic [1:0] cp      [2];
  logic [3:0] f0      [2];
  logic [3:0] f1      [2];

  int mode [2][4];   // 0 normal, 1 stuck-0, 2 stuck-1, 3 delayed
  int dly  [2][4];
  logic [3:0] hist [2][16];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  path_test_sequencer #(.NUM_PATHS(NP), .SETTLE_CYCLES(2), .INV_MASK(INV)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]),
`ifdef PATH_MASK_EN
    .path_en(path_en[0]),
`endif
    .resp_i(resp[0]), .stim_o(stim[0]), .busy(busy[0]), .done(done[0]),
    .cur_path(cp[0]), .fail0(f0[0]), .fail1(f1[0]));

  path_test_sequencer #(.NUM_PATHS(NP), .SETTLE_CYCLES(4), .INV_MASK(INV)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]),
`ifdef PATH_MASK_EN
    .path_en(path_en[1]),
`endif
    .resp_i(resp[1]), .stim_o(stim[1]), .busy(busy[1]), .done(done[1]),
    .cur_path(cp[1]), .fail0(f0[1]), .fail1(f1[1]));

  // Stimulus history: hist[k][j] is the stimulus seen j+1 edges ago.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int j = 15; j > 0; j--) hist[k][j] <= hist[k][j-1];
      hist[k][0] <= stim[k];
    end
  end

  // Path models.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      resp[k] = '0;
      for (int i = 0; i < NP; i++) begin
        case (mode[k][i])
          1: resp[k][i] = 1'b0;
          2: resp[k][i] = 1'b1;
          3: resp[k][i] = ((dly[k][i] == 0) ? stim[k][i] : hist[k][dly[k][i]-1][i]) ^ INV[i];
          default: resp[k][i] = stim[k][i] ^ INV[i];
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic clear_faults(input int k);
    for (int i = 0; i < NP; i++) begin mode[k][i] = 0; dly[k][i] = 0; end
  endtask

  // Would a path with this fault report a mismatch for stimulus s?
  // A delayed path that cannot settle still shows the pre-phase level, which
  // is always stimulus 0, so its response is just the inversion bit.
  function automatic logic exp_fail(input int k, input int i, input logic s);
    logic e;
    e = s ^ INV[i];
    case (mode[k][i])
      1: return e != 1'b0;
      2: return e != 1'b1;
      3: return (dly[k][i] > SET[k]) ? (INV[i] != e) : 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  // One run on instance k. mid: cycle to pulse start (0 = never).
  // rc: cycle at which reset is asserted (0 = never).
  task automatic run(input int k, input logic [3:0] en, input int mid, input int rc);
    int q[$];
    int len, p, pth;
    logic [3:0] mask, e0, e1, es;
`ifdef PATH_MASK_EN
    mask = en;
`else
    mask = 4'hF;
`endif
    e0 = '0; e1 = '0;
    for (int i = 0; i < NP; i++) if (mask[i]) begin
      q.push_back(i);
      e0[i] = exp_fail(k, i, 1'b0);
      e1[i] = exp_fail(k, i, 1'b1);
    end
    len = q.size() * 2 * (SET[k] + 1);
    repeat (2) @(negedge clk);
    start[k] = 1'b1; path_en[k] = en;
    @(negedge clk);
    start[k] = 1'b0;
    for (int t = 1; t <= len; t++) begin
      p   = (t - 1) / (SET[k] + 1);
      pth = q[p / 2];
      es  = (p % 2 == 1) ? (4'b0001 << pth) : 4'b0000;
      chk($sformatf("busy k%0d t%0d", k, t), 32'(busy[k]), 32'd1);
      chk($sformatf("done k%0d t%0d", k, t), 32'(done[k]), 32'd0);
      chk($sformatf("stim k%0d t%0d", k, t), 32'(stim[k]), 32'(es));
      chk($sformatf("cur k%0d t%0d", k, t), 32'(cp[k]), 32'(pth));
      if (t == rc) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst stim", 32'(stim[k]), 32'd0);
        chk("rst busy", 32'(busy[k]), 32'd0);
        chk("rst cur", 32'(cp[k]), 32'd0);
        chk("rst fails", 32'({f0[k], f1[k]}), 32'd0);
        for (int j = 0; j < len; j++) begin
          chk("rst no done", 32'(done[k]), 32'd0);
          @(negedge clk);
        end
        return;
      end
      start[k] = (t == mid);
      @(negedge clk);
    end
    start[k] = 1'b0;
    chk($sformatf("done pulse k%0d", k), 32'(done[k]), 32'd1);
    chk($sformatf("fin busy k%0d", k), 32'(busy[k]), 32'd0);
    chk($sformatf("fin stim k%0d", k), 32'(stim[k]), 32'd0);
    chk($sformatf("fail0 k%0d", k), 32'(f0[k]), 32'(e0));
    chk($sformatf("fail1 k%0d", k), 32'(f1[k]), 32'(e1));
    @(negedge clk);
    chk($sformatf("done drop k%0d", k), 32'(done[k]), 32'd0);
    chk($sformatf("fail hold k%0d", k), 32'({f0[k], f1[k]}), 32'({e0, e1}));
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; path_en[k] = 4'hF; clear_faults(k);
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("reset stim", 32'(stim[k]), 32'd0);
      chk("reset busy", 32'(busy[k]), 32'd0);
      chk("reset done", 32'(done[k]), 32'd0);
      chk("reset cur", 32'(cp[k]), 32'd0);
      chk("reset fails", 32'({f0[k], f1[k]}), 32'd0);
    end
    repeat (20) @(negedge clk);

    // Fault-free run: 24 busy cycles, done in cycle 25.
    run(0, 4'hF, 0, 0);
    chk("tp clean", 32'({f0[0], f1[0]}), 32'h00);

    // Stuck-at-0 on path 2.
    mode[0][2] = 1;
    run(0, 4'hF, 0, 0);
    chk("tp sa0 p2", 32'({f0[0], f1[0]}), 32'h04);
    clear_faults(0);

    // Stuck-at-1 on inverting path 0.
    mode[0][0] = 2;
    run(0, 4'hF, 0, 0);
    chk("tp sa1 p0", 32'({f0[0], f1[0]}), 32'h01);
    clear_faults(0);

    // Slow path 3: fails at settle 2, passes at settle 4.
    mode[0][3] = 3; dly[0][3] = 4;
    mode[1][3] = 3; dly[1][3] = 4;
    run(0, 4'hF, 0, 0);
    chk("tp slow s2", 32'({f0[0], f1[0]}), 32'h08);
    run(1, 4'hF, 0, 0);
    chk("tp slow s4", 32'({f0[1], f1[1]}), 32'h00);
    clear_faults(0); clear_faults(1);

    // Delay exactly equal to the settle time still passes.
    mode[0][1] = 3; dly[0][1] = 2;
    run(0, 4'hF, 0, 0);
    clear_faults(0);

    // start mid-run ignored; then reset aborts a run.
    run(0, 4'hF, 10, 0);
    mode[0][1] = 1;
    run(0, 4'hF, 0, 12);
    clear_faults(0);

`ifdef PATH_MASK_EN
    mode[0][0] = 1; mode[0][3] = 1;
    run(0, 4'b1010, 0, 0);
    run(0, 4'b0000, 0, 0);
    clear_faults(0);
`endif

    // Random fault mixes.
    for (int r = 0; r < 24; r++) begin
      int k;
      k = int'($urandom_range(0, 1));
      for (int i = 0; i < NP; i++) begin
        mode[k][i] = int'($urandom_range(0, 3));
        dly[k][i]  = int'($urandom_range(0, 6));
      end
      run(k, 4'($urandom_range(0, 15)), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
